tiny8_mem: RTL
==============

# tiny8_mem

Memory responder for the tiny8 core: a 256 x 8 synchronous RAM behind the same read/write request, response handshake the core's datapath and control drive when fetching instructions and loading/storing operands. The block captures one request, inserts a fixed number of wait states, then completes it with a single-cycle response strobe. It sits beside the core at top level, connected directly to the core's memory port, and serves as both the simulation memory and the synthesizable on-chip store.

## Interface
Parameters:
- WAIT_CYCLES, 2, wait states between request capture and response; legal 0..15.
- PROTECT_TOP, 8'h3F, highest write-protected address; used only with TINY8_MEM_WRPROTECT_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_address  input  8  byte address.
- mem_wdata  input  8  write data.
- mem_rdata  output  8  read data; valid in the mem_resp cycle; holds until the next read completes.
- mem_resp  output  1  one-cycle completion strobe.
- mem_err  output  1  protection-violation strobe, coincident with mem_resp (present only with TINY8_MEM_WRPROTECT_EN).

## Operation
- FSM states IDLE, WAIT, RESP (tiny8_mem_state).
- IDLE: if mem_write or mem_read is sampled high, latch op, address and wdata. Write wins if both are high; the read is dropped. Load the 4-bit wait counter with WAIT_CYCLES. Go to WAIT, or go directly to RESP when WAIT_CYCLES==0.
- WAIT: decrement the counter; on the counter==1 edge go to RESP. Input changes during WAIT/RESP are ignored (latched copy used).
- RESP: assert mem_resp. A read drives mem_rdata from the array at the latched address. A write updates the array at the latched address on the edge ending RESP. Return to IDLE.
- Back-to-back: a request sampled in the IDLE cycle right after RESP starts a new transaction. No bubble beyond that IDLE cycle.
- Read-after-write to the same address returns the newly written byte.
- Address is 8 bits; the full 256 entries are always decoded. No wrap logic is needed.

## Timing
- Request first high in cycle 0 (IDLE) -> mem_resp high in cycle WAIT_CYCLES+1, for exactly one cycle.
- WAIT_CYCLES=0 -> mem_resp in cycle 1.
- Reset values: state IDLE, counter 0, mem_resp 0, mem_rdata 8'h00, mem_err 0. Array contents are not reset.
- rst asserted mid-transaction aborts it: no response and no array write, including a write in RESP.
- mem_rdata changes only in a read RESP cycle or on reset. A write completion leaves it unchanged.

## Configuration
- TINY8_MEM_WRPROTECT_EN defined:
  - A write with latched address <= PROTECT_TOP still completes the handshake (mem_resp pulses) but does not modify the array.
  - mem_err pulses high in that RESP cycle.
  - Reads are never blocked.
- Undefined: mem_err port and all protection logic are absent; every write updates the array.

## Structure
- tiny8_types package: tiny8_word (8-bit), tiny8_mem_state enum, TINY8_MEM_DEPTH=256, wait-counter width constant.
- Sub-module tiny8_mem_array holds the storage: a single-port 256 x 8 array with synchronous write enable, combinational read, and no reset. The FSM, counter, latches and protection logic stay in tiny8_mem.

## Test plan
- WAIT_CYCLES=2: write 8'hA5 to 8'h40 from cycle 0 -> mem_resp only in cycle 3. Then read 8'h40 -> mem_rdata=8'hA5 with mem_resp 3 cycles after the request.
- WAIT_CYCLES=0: back-to-back reads of 8'h00 and 8'hFF (preloaded 8'h11, 8'h22) -> resp in cycles 1 and 3, data 8'h11 then 8'h22.
- mem_read and mem_write both high, address 8'h50, wdata 8'h77 -> treated as a write. A subsequent read of 8'h50 returns 8'h77; mem_rdata unchanged at the write's resp.
- rst asserted in the RESP cycle of a write of 8'hCC to 8'h60 -> no mem_resp, location keeps its old value, all outputs 0 the next cycle.
- Change mem_address from 8'h10 to 8'h20 during WAIT -> response carries the contents of 8'h10.
- With TINY8_MEM_WRPROTECT_EN, write 8'h99 to 8'h3F -> mem_resp and mem_err pulse together, readback unchanged. Write to 8'h40 -> mem_err 0, data stored.

Source files
------------

// File: rtl/tiny8_mem_pkg.sv
// ----------------------------------------------------------------------------
// tiny8_types : shared types and constants for the tiny8 memory responder.
//
// Contents:
//   tiny8_word        8-bit data word
//   tiny8_addr        8-bit byte address
//   tiny8_wait_cnt    wait-state counter (TINY8_MEM_WAIT_W bits, 0..15)
//   tiny8_mem_state   responder FSM states IDLE / WAIT / RESP
//   tiny8_mem_op      latched operation kind (read or write)
//   TINY8_MEM_DEPTH   number of storage locations (256)
// ----------------------------------------------------------------------------
package tiny8_types;

    localparam int TINY8_MEM_DEPTH  = 256;
    localparam int TINY8_MEM_WAIT_W = 4;

    typedef logic [7:0]                  tiny8_word;
    typedef logic [7:0]                  tiny8_addr;
    typedef logic [TINY8_MEM_WAIT_W-1:0] tiny8_wait_cnt;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } tiny8_mem_state;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } tiny8_mem_op;

endpackage

// File: rtl/tiny8_mem_if.sv
// ----------------------------------------------------------------------------
// tiny8_mem_if : request/response bus between the tiny8 core and its memory.
//
// Signals:
//   mem_read     read request, held by the initiator until mem_resp
//   mem_write    write request, held by the initiator until mem_resp
//   mem_address  byte address
//   mem_wdata    write data
//   mem_rdata    read data, valid in the mem_resp cycle, held afterwards
//   mem_resp     one-cycle completion strobe
//   mem_err      protection-violation strobe (only with TINY8_MEM_WRPROTECT_EN)
//
// Modports: master (core side), slave (memory side).
// Optional feature macro: TINY8_MEM_WRPROTECT_EN adds mem_err.
// ----------------------------------------------------------------------------
interface tiny8_mem_if;
    import tiny8_types::*;

    logic      mem_read;
    logic      mem_write;
    tiny8_addr mem_address;
    tiny8_word mem_wdata;
    tiny8_word mem_rdata;
    logic      mem_resp;
`ifdef TINY8_MEM_WRPROTECT_EN
    logic      mem_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp, mem_err
    );
`else
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
`endif

endinterface

// File: rtl/tiny8_mem_array.sv
// ----------------------------------------------------------------------------
// tiny8_mem_array : single-port 256 x 8 storage for tiny8_mem.
//
// Ports:
//   clk    clock, write happens on the rising edge
//   we     write enable
//   addr   shared read/write address
//   wdata  write data
//   rdata  combinational read data at addr
//
// The contents are deliberately not reset.
// ----------------------------------------------------------------------------
module tiny8_mem_array
    import tiny8_types::*;
(
    input  logic      clk,
    input  logic      we,
    input  tiny8_addr addr,
    input  tiny8_word wdata,
    output tiny8_word rdata
);

    tiny8_word mem [TINY8_MEM_DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tiny8_mem.sv
// ----------------------------------------------------------------------------
// tiny8_mem : memory responder for the tiny8 core.
//
// Captures one read or write request from the bus, waits WAIT_CYCLES wait
// states, then completes it with a single-cycle mem_resp strobe. Storage is
// a 256 x 8 array in tiny8_mem_array.
//
// Parameters:
//   WAIT_CYCLES  wait states between capture and response (0..15)
//   PROTECT_TOP  highest write-protected address (only with the macro below)
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   tiny8_mem_if.slave (mem_read, mem_write, mem_address, mem_wdata,
//         mem_rdata, mem_resp, mem_err)
//
// Optional feature macro: TINY8_MEM_WRPROTECT_EN
//   Writes to addresses <= PROTECT_TOP complete the handshake without
//   modifying the array and pulse mem_err together with mem_resp.
// ----------------------------------------------------------------------------
module tiny8_mem
    import tiny8_types::*;
#(
    parameter int WAIT_CYCLES = 2
`ifdef TINY8_MEM_WRPROTECT_EN
    ,
    parameter tiny8_addr PROTECT_TOP = 8'h3F
`endif
)
(
    input  logic        clk,
    input  logic        rst,
    tiny8_mem_if.slave  bus
);

    localparam tiny8_wait_cnt WAIT_INIT = tiny8_wait_cnt'(WAIT_CYCLES);
    localparam tiny8_wait_cnt CNT_ONE   = tiny8_wait_cnt'(1);

    tiny8_mem_state state;
    tiny8_wait_cnt  wait_cnt;
    tiny8_mem_op    op_q;
    tiny8_addr      addr_q;
    tiny8_word      wdata_q;
    tiny8_word      rdata_q;
    logic           resp_q;

    tiny8_addr      array_addr;
    tiny8_word      array_rdata;
    logic           array_we;
    logic           capture_write;

`ifdef TINY8_MEM_WRPROTECT_EN
    logic           capture_prot;
    logic           prot_q;
    logic           err_q;

    assign capture_prot = capture_write && (bus.mem_address <= PROTECT_TOP);
`endif

    // Write wins when both request lines are high; the read is dropped.
    assign capture_write = bus.mem_write;

    // The array has a single port. In IDLE it looks at the live bus address
    // so a zero-wait read can fetch its data on the capture edge; otherwise
    // it uses the latched address so bus changes mid-transaction are ignored.
    assign array_addr = (state == IDLE) ? bus.mem_address : addr_q;

    // The write lands on the edge that ends RESP; a reset on that edge
    // cancels it.
`ifdef TINY8_MEM_WRPROTECT_EN
    assign array_we = (state == RESP) && (op_q == OP_WRITE) && !prot_q && !rst;
`else
    assign array_we = (state == RESP) && (op_q == OP_WRITE) && !rst;
`endif

    tiny8_mem_array u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (array_addr),
        .wdata (wdata_q),
        .rdata (array_rdata)
    );

    // Responder FSM: capture in IDLE, count wait states in WAIT, strobe in
    // RESP. Response strobe and read data are registered on the edge that
    // enters RESP, so they appear exactly in the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
`ifdef TINY8_MEM_WRPROTECT_EN
            prot_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            resp_q <= 1'b0;
`ifdef TINY8_MEM_WRPROTECT_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.mem_write || bus.mem_read) begin
                        op_q     <= capture_write ? OP_WRITE : OP_READ;
                        addr_q   <= bus.mem_address;
                        wdata_q  <= bus.mem_wdata;
                        wait_cnt <= WAIT_INIT;
`ifdef TINY8_MEM_WRPROTECT_EN
                        prot_q   <= capture_prot;
`endif
                        if (WAIT_CYCLES == 0) begin
                            state  <= RESP;
                            resp_q <= 1'b1;
                            if (!capture_write) begin
                                rdata_q <= array_rdata;
                            end
`ifdef TINY8_MEM_WRPROTECT_EN
                            err_q  <= capture_prot;
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_ONE;
                    if (wait_cnt == CNT_ONE) begin
                        state  <= RESP;
                        resp_q <= 1'b1;
                        if (op_q == OP_READ) begin
                            rdata_q <= array_rdata;
                        end
`ifdef TINY8_MEM_WRPROTECT_EN
                        err_q  <= prot_q;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are masked while rst is high so a transaction aborted in its
    // RESP cycle never shows a completion to the initiator.
    assign bus.mem_resp  = resp_q && !rst;
    assign bus.mem_rdata = rdata_q;
`ifdef TINY8_MEM_WRPROTECT_EN
    assign bus.mem_err   = err_q && !rst;
`endif

endmodule
